// File: rtl/call_scheduler.sv
// Bank call scheduler: issues tickets, tracks five counters and presents one call/recall at a time.
// Build option CALL_RR_ARB_EN selects round-robin counter choice; otherwise fixed priority, A first.
module call_scheduler #(
  parameter int unsigned TKT_W      = 6,
  parameter int unsigned MAX_TICKET = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             take_ticket,
  input  logic [4:0]       done,
  input  logic [4:0]       recall,
  input  logic             call_ack,
  output logic [TKT_W-1:0] ticket_issued,
  output logic [TKT_W-1:0] waiting,
  output logic             queue_full,
  output logic [4:0]       counter_busy,
  output logic             call_valid,
  output logic [2:0]       call_counter,
  output logic [TKT_W-1:0] call_number,
  output logic             call_is_recall
);

  typedef enum logic [0:0] {StIdle, StCall} state_e;

  state_e           state_q;
  logic [TKT_W-1:0] issue_ptr_q;
  logic [TKT_W-1:0] serve_ptr_q;
  logic [TKT_W-1:0] waiting_q;
  logic [TKT_W-1:0] ticket_q;
  logic [4:0]       busy_q;
  logic [4:0]       rec_pend_q;
  logic [TKT_W-1:0] stored_q [5];
  logic             call_valid_q;
  logic [2:0]       call_counter_q;
  logic [TKT_W-1:0] call_number_q;
  logic             call_recall_q;

  logic       take_ok;
  logic       in_idle;
  logic [4:0] call_mask;
  logic [4:0] done_eff;
  logic [3:0] rec_sel;
  logic [3:0] free_sel;
  logic       do_recall;
  logic       do_assign;
  logic [2:0] sel_idx;
  logic [4:0] sel_mask;
  logic [2:0] start_idx;

  // Returns {found, index}: first set bit of mask scanning upward from start, wrapping E -> A.
  function automatic logic [3:0] pick(input logic [4:0] mask, input logic [2:0] start);
    logic [3:0] res;
    logic [3:0] pos;
    res = 4'b0;
    for (int k = 0; k < 5; k++) begin
      pos = {1'b0, start} + 4'(k);
      if (pos >= 4'd5) pos = pos - 4'd5;
      if (!res[3] && mask[pos[2:0]]) res = {1'b1, pos[2:0]};
    end
    return res;
  endfunction

  function automatic logic [TKT_W-1:0] next_ptr(input logic [TKT_W-1:0] p);
    return (p == TKT_W'(MAX_TICKET)) ? TKT_W'(1) : p + TKT_W'(1);
  endfunction

`ifdef CALL_RR_ARB_EN
  logic [2:0] last_q;
  assign start_idx = (last_q == 3'd4) ? 3'd0 : last_q + 3'd1;
`else
  assign start_idx = 3'd0;
`endif

  assign queue_full = (waiting_q == TKT_W'(MAX_TICKET));

  always_comb begin
    take_ok   = take_ticket && !queue_full;
    in_idle   = (state_q == StIdle);
    call_mask = 5'b0;
    // The counter whose call is on display cannot be released under it.
    if (state_q == StCall) call_mask = 5'b1 << (call_counter_q - 3'd1);
    done_eff  = done & ~call_mask;
    rec_sel   = pick(rec_pend_q, start_idx);
    free_sel  = pick(~busy_q, start_idx);
    do_recall = in_idle && rec_sel[3];
    do_assign = in_idle && !rec_sel[3] && free_sel[3] && (waiting_q != '0);
    sel_idx   = do_recall ? rec_sel[2:0] : free_sel[2:0];
    sel_mask  = 5'b1 << sel_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      issue_ptr_q    <= TKT_W'(1);
      serve_ptr_q    <= TKT_W'(1);
      waiting_q      <= '0;
      ticket_q       <= '0;
      busy_q         <= 5'b0;
      rec_pend_q     <= 5'b0;
      for (int i = 0; i < 5; i++) stored_q[i] <= '0;
      call_valid_q   <= 1'b0;
      call_counter_q <= 3'd0;
      call_number_q  <= '0;
      call_recall_q  <= 1'b0;
`ifdef CALL_RR_ARB_EN
      last_q         <= 3'd4;
`endif
    end else begin
      if (take_ok) begin
        ticket_q    <= issue_ptr_q;
        issue_ptr_q <= next_ptr(issue_ptr_q);
      end

      if (take_ok && !do_assign) begin
        waiting_q <= waiting_q + TKT_W'(1);
      end else if (!take_ok && do_assign) begin
        waiting_q <= waiting_q - TKT_W'(1);
      end

      busy_q     <= (busy_q & ~done_eff) | (do_assign ? sel_mask : 5'b0);
      rec_pend_q <= (rec_pend_q | (recall & busy_q)) & ~done_eff
                    & ~(do_recall ? sel_mask : 5'b0);

      if (do_assign) begin
        stored_q[sel_idx] <= serve_ptr_q;
        serve_ptr_q       <= next_ptr(serve_ptr_q);
      end

      unique case (state_q)
        StIdle: begin
          if (do_recall || do_assign) begin
            state_q        <= StCall;
            call_valid_q   <= 1'b1;
            call_counter_q <= sel_idx + 3'd1;
            call_number_q  <= do_recall ? stored_q[sel_idx] : serve_ptr_q;
            call_recall_q  <= do_recall;
`ifdef CALL_RR_ARB_EN
            last_q         <= sel_idx;
`endif
          end
        end
        StCall: begin
          if (call_ack) begin
            state_q        <= StIdle;
            call_valid_q   <= 1'b0;
            call_counter_q <= 3'd0;
            call_number_q  <= '0;
            call_recall_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ticket_issued  = ticket_q;
  assign waiting        = waiting_q;
  assign counter_busy   = busy_q;
  assign call_valid     = call_valid_q;
  assign call_counter   = call_counter_q;
  assign call_number    = call_number_q;
  assign call_is_recall = call_recall_q;

endmodule

// File: tb/tb_call_scheduler.sv
// Bench for call_scheduler: directed scenarios plus random traffic, scored against a queue-based model.
module tb_call_scheduler;

  localparam int TKT_W = 6;
  localparam int MAX   = 50;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             take_ticket = 1'b0;
  logic [4:0]       done = 5'b0;
  logic [4:0]       recall = 5'b0;
  logic             call_ack = 1'b0;
  logic [TKT_W-1:0] ticket_issued;
  logic [TKT_W-1:0] waiting;
  logic             queue_full;
  logic [4:0]       counter_busy;
  logic             call_valid;
  logic [2:0]       call_counter;
  logic [TKT_W-1:0] call_number;
  logic             call_is_recall;

  always #5 clk = ~clk;

  call_scheduler #(
    .TKT_W      (TKT_W),
    .MAX_TICKET (MAX)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .take_ticket    (take_ticket),
    .done           (done),
    .recall         (recall),
    .call_ack       (call_ack),
    .ticket_issued  (ticket_issued),
    .waiting        (waiting),
    .queue_full     (queue_full),
    .counter_busy   (counter_busy),
    .call_valid     (call_valid),
    .call_counter   (call_counter),
    .call_number    (call_number),
    .call_is_recall (call_is_recall)
  );

  typedef struct {
    int ctr;
    int num;
    int rec;
  } call_t;

  // Reference model: waiting tickets as a FIFO of numbers, counters as flat arrays.
  call_t exp_q[$];
  call_t cur;
  int    wq[$];
  bit    m_busy[5];
  int    m_num[5];
  bit    m_rec[5];
  bit    m_call;
  int    m_ctr;
  int    m_last;
  int    m_next;
  int    m_issued;
  bit    prev_v = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int pick(input logic [4:0] m);
    int start = 0;
    int idx;
`ifdef CALL_RR_ARB_EN
    start = (m_last + 1) % 5;
`endif
    for (int k = 0; k < 5; k++) begin
      idx = (start + k) % 5;
      if (m[idx[2:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [4:0] rmask;
    logic [4:0] fmask;
    bit         busy_old[5];
    bit         deff[5];
    int         sel;
    bit         fire;
    bit         is_rec;
    bit         take_ok;
    call_t      c;
    if (rst) begin
      exp_q.delete();
      wq.delete();
      for (int i = 0; i < 5; i++) begin
        m_busy[i] = 1'b0;
        m_num[i]  = 0;
        m_rec[i]  = 1'b0;
      end
      m_call   = 1'b0;
      m_ctr    = 0;
      m_last   = 4;
      m_next   = 1;
      m_issued = 0;
      return;
    end
    for (int i = 0; i < 5; i++) begin
      busy_old[i] = m_busy[i];
      rmask[i]    = m_rec[i];
      fmask[i]    = !m_busy[i];
      deff[i]     = done[i] && !(m_call && m_ctr == i);
    end
    fire   = 1'b0;
    is_rec = 1'b0;
    sel    = -1;
    if (!m_call) begin
      sel = pick(rmask);
      if (sel >= 0) begin
        fire   = 1'b1;
        is_rec = 1'b1;
      end else if (wq.size() > 0) begin
        sel  = pick(fmask);
        fire = (sel >= 0);
      end
    end
    take_ok = take_ticket && (wq.size() != MAX);
    if (fire) begin
      c.ctr = sel + 1;
      if (is_rec) begin
        c.num = m_num[sel];
        c.rec = 1;
      end else begin
        c.num      = wq.pop_front();
        m_num[sel] = c.num;
        c.rec      = 0;
      end
      exp_q.push_back(c);
    end
    for (int i = 0; i < 5; i++) begin
      m_rec[i]  = (m_rec[i] || (recall[i] && busy_old[i])) && !deff[i]
                  && !(fire && is_rec && sel == i);
      m_busy[i] = (busy_old[i] && !deff[i]) || (fire && !is_rec && sel == i);
    end
    if (take_ok) begin
      m_issued = m_next;
      wq.push_back(m_next);
      m_next = (m_next == MAX) ? 1 : m_next + 1;
    end
    if (m_call && call_ack) m_call = 1'b0;
    if (fire) begin
      m_call = 1'b1;
      m_ctr  = sel;
      m_last = sel;
    end
  endtask

  task automatic monitor();
    int busy_exp;
    busy_exp = 0;
    for (int i = 0; i < 5; i++) if (m_busy[i]) busy_exp += (1 << i);
    chk("ticket_issued", int'(ticket_issued), m_issued);
    chk("waiting", int'(waiting), wq.size());
    chk("queue_full", int'(queue_full), int'(wq.size() == MAX));
    chk("counter_busy", int'(counter_busy), busy_exp);
    chk("call_valid", int'(call_valid), int'(m_call));
    if (call_valid && !prev_v) begin
      chk("call_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) cur = exp_q.pop_front();
    end
    if (call_valid) begin
      chk("call_counter", int'(call_counter), cur.ctr);
      chk("call_number", int'(call_number), cur.num);
      chk("call_is_recall", int'(call_is_recall), cur.rec);
    end else begin
      chk("call_counter_idle", int'(call_counter), 0);
    end
    prev_v = call_valid;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    monitor();
  end

  task automatic step(input bit t, input logic [4:0] d, input logic [4:0] r, input bit a);
    take_ticket = t;
    done        = d;
    recall      = r;
    call_ack    = a;
    @(negedge clk);
  endtask

  task automatic idle_ack(input int n);
    repeat (n) step(1'b0, 5'b0, 5'b0, call_valid);
  endtask

  initial begin
    repeat (3) step(1'b0, 5'b0, 5'b0, 1'b0);
    rst = 1'b0;

    // Three tickets onto free counters, then release A and issue two more.
    repeat (3) step(1'b1, 5'b0, 5'b0, 1'b0);
    idle_ack(20);
    step(1'b0, 5'b00001, 5'b0, 1'b0);
    step(1'b1, 5'b0, 5'b0, 1'b0);
    step(1'b1, 5'b0, 5'b0, 1'b0);
    idle_ack(20);

    // One ticket, call left unacknowledged for a while.
    step(1'b1, 5'b0, 5'b0, 1'b0);
    repeat (12) step(1'b0, 5'b0, 5'b0, 1'b0);
    idle_ack(5);

    // Recalls on busy counters, one racing a new ticket; recall on a just-freed counter.
    step(1'b0, 5'b0, 5'b00001, 1'b0);
    idle_ack(8);
    step(1'b1, 5'b0, 5'b00010, 1'b0);
    idle_ack(8);
    step(1'b0, 5'b01000, 5'b0, 1'b0);
    step(1'b0, 5'b0, 5'b01000, 1'b0);
    idle_ack(8);

    // done for the counter currently being called must not free it.
    step(1'b1, 5'b0, 5'b0, 1'b0);
    step(1'b0, 5'b00010, 5'b0, 1'b0);
    step(1'b0, 5'b0, 5'b0, 1'b0);
    step(1'b0, 5'b00010, 5'b0, 1'b0);
    idle_ack(6);

    // Fill the queue with every counter busy, overflow once, then drain one.
    rst = 1'b1;
    step(1'b0, 5'b0, 5'b0, 1'b0);
    rst = 1'b0;
    repeat (5) begin
      step(1'b1, 5'b0, 5'b0, 1'b0);
      idle_ack(4);
    end
    repeat (51) step(1'b1, 5'b0, 5'b0, 1'b0);
    step(1'b0, 5'b00010, 5'b0, 1'b0);
    idle_ack(5);
    step(1'b1, 5'b0, 5'b0, 1'b0);
    idle_ack(3);

    // Reset while a call is on display.
    step(1'b0, 5'b00100, 5'b0, 1'b0);
    step(1'b0, 5'b0, 5'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 5'b0, 5'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 5'b0, 5'b0, 1'b0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 3) == 0,
           5'($urandom & $urandom & $urandom),
           5'($urandom & $urandom & $urandom),
           call_valid && (($urandom % 3) != 0));
    end
    idle_ack(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
